bucket_table: RTL and testbench

Consumer end of the hasher output interface. Takes (h1 signature, h2 bucket index) pairs and either inserts the signature into its bucket or queries whether the bucket already holds it. Each bucket stores up to BUCKET_DEPTH 32-bit signatures and is scanned one slot per cycle. The block sits directly downstream of the hasher in the LSH datapath, behind a valid/ready handshake.

---
 rtl/lsh_pkg.sv | 21 ++
 rtl/bucket_table_if.sv | 33 +++
 rtl/bucket_mem.sv | 58 +++++
 rtl/bucket_table.sv | 171 +++++++++++++++++
 tb/tb_bucket_table.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsh_pkg.sv
// Shared definitions for the LSH datapath: default sizes, opcodes and the
// bucket table state encoding.
package lsh_pkg;

  localparam int NUM_OF_BUCKETS = 256;
  localparam int BUCKET_DEPTH   = 4;
  localparam int KMER_SIZE      = 16;
  localparam int SIG_WIDTH      = 32;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_QUERY  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/bucket_table_if.sv
// Request/response channel between the hasher and the bucket table.
interface bucket_table_if #(
  parameter int NUM_OF_BUCKETS = lsh_pkg::NUM_OF_BUCKETS,
  parameter int BUCKET_DEPTH   = lsh_pkg::BUCKET_DEPTH,
  parameter int SIG_WIDTH      = lsh_pkg::SIG_WIDTH
);
  localparam int BW = $clog2(NUM_OF_BUCKETS);
  localparam int SW = $clog2(BUCKET_DEPTH);
  localparam int CW = $clog2(BUCKET_DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_op;
  logic [SIG_WIDTH-1:0] in_h1;
  logic [BW-1:0]        in_h2;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_hit;
  logic                 out_full;
  logic [SW-1:0]        out_slot;
  logic [CW-1:0]        out_count;

  modport master (
    output in_valid, in_op, in_h1, in_h2, out_ready,
    input  in_ready, out_valid, out_hit, out_full, out_slot, out_count
  );

  modport slave (
    input  in_valid, in_op, in_h1, in_h2, out_ready,
    output in_ready, out_valid, out_hit, out_full, out_slot, out_count
  );

endinterface

// File: rtl/bucket_mem.sv
// Bucket storage: per-bucket occupancy counters plus the signature array with
// one combinational read port and one write port.
module bucket_mem #(
  parameter int NUM_OF_BUCKETS = lsh_pkg::NUM_OF_BUCKETS,
  parameter int BUCKET_DEPTH   = lsh_pkg::BUCKET_DEPTH,
  parameter int SIG_WIDTH      = lsh_pkg::SIG_WIDTH,
  localparam int BW = $clog2(NUM_OF_BUCKETS),
  localparam int SW = $clog2(BUCKET_DEPTH),
  localparam int CW = $clog2(BUCKET_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [BW-1:0]        cnt_rd_bucket,
  output logic [CW-1:0]        cnt_rd,
  input  logic                 cnt_wr_en,
  input  logic [BW-1:0]        cnt_wr_bucket,
  input  logic [CW-1:0]        cnt_wr_val,
  input  logic [BW-1:0]        sig_rd_bucket,
  input  logic [SW-1:0]        sig_rd_slot,
  output logic [SIG_WIDTH-1:0] sig_rd,
  input  logic                 sig_wr_en,
  input  logic [BW-1:0]        sig_wr_bucket,
  input  logic [SW-1:0]        sig_wr_slot,
  input  logic [SIG_WIDTH-1:0] sig_wr_data
);

  logic [CW-1:0]        cnt_all [NUM_OF_BUCKETS];
  logic [SIG_WIDTH-1:0] sig_mem [NUM_OF_BUCKETS][BUCKET_DEPTH];

  // Counters are individual registers so a clear empties every bucket in one edge.
  genvar gi;
  for (gi = 0; gi < NUM_OF_BUCKETS; gi++) begin : g_cnt
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
        cnt_reg <= '0;
      end else if (cnt_wr_en && (cnt_wr_bucket == BW'(gi))) begin
        cnt_reg <= cnt_wr_val;
      end
    end

    assign cnt_all[gi] = cnt_reg;
  end

  assign cnt_rd = cnt_all[cnt_rd_bucket];

  // Slots beyond a bucket's count are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (sig_wr_en) begin
      sig_mem[sig_wr_bucket][sig_wr_slot] <= sig_wr_data;
    end
  end

  assign sig_rd = sig_mem[sig_rd_bucket][sig_rd_slot];

endmodule

// File: rtl/bucket_table.sv
// Bucket table: accepts (signature, bucket) requests, scans the bucket one slot
// per cycle, then inserts or reports a hit and holds the response until taken.
module bucket_table #(
  parameter int NUM_OF_BUCKETS = lsh_pkg::NUM_OF_BUCKETS,
  parameter int BUCKET_DEPTH   = lsh_pkg::BUCKET_DEPTH,
  parameter int SIG_WIDTH      = lsh_pkg::SIG_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  bucket_table_if.slave  bus
);
  import lsh_pkg::*;

  localparam int BW = $clog2(NUM_OF_BUCKETS);
  localparam int SW = $clog2(BUCKET_DEPTH);
  localparam int CW = $clog2(BUCKET_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUCKET_DEPTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SCAN = SCAN;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]           state_reg, state_next;
  op_e                  op_reg;
  logic [SIG_WIDTH-1:0] h1_reg;
  logic [BW-1:0]        h2_reg;
  logic [CW-1:0]        cnt_reg;
  logic [SW-1:0]        idx_reg, idx_next;

  logic                 hit_reg, full_reg;
  logic [SW-1:0]        slot_reg;
  logic [CW-1:0]        count_reg;

  logic [CW-1:0]        cnt_rd;
  logic [SIG_WIDTH-1:0] sig_rd;
  logic                 in_ready;
  logic                 accept;

  // Resolution operands: taken straight from the request for an empty bucket,
  // otherwise from the latched request at the end of the scan.
  logic                 go_resp;
  op_e                  res_op;
  logic [SIG_WIDTH-1:0] res_h1;
  logic [BW-1:0]        res_h2;
  logic [CW-1:0]        res_cnt;
  logic                 res_hit;
  logic [SW-1:0]        res_slot;

  logic                 is_insert;
  logic                 do_write;
  logic                 full_next;
  logic [SW-1:0]        slot_next;
  logic [CW-1:0]        count_next;

  assign in_ready = rst_n && (state_reg == S_IDLE) && !clear;
  assign accept   = in_ready && bus.in_valid;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    go_resp    = 1'b0;
    res_op     = op_reg;
    res_h1     = h1_reg;
    res_h2     = h2_reg;
    res_cnt    = cnt_reg;
    res_hit    = 1'b0;
    res_slot   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          idx_next = '0;
          if (cnt_rd != '0) begin
            state_next = S_SCAN;
          end else begin
            state_next = S_RESP;
            go_resp    = 1'b1;
            res_op     = op_e'(bus.in_op);
            res_h1     = bus.in_h1;
            res_h2     = bus.in_h2;
            res_cnt    = cnt_rd;
          end
        end
      end
      S_SCAN: begin
        if (sig_rd == h1_reg) begin
          state_next = S_RESP;
          go_resp    = 1'b1;
          res_hit    = 1'b1;
        end else if ({1'b0, idx_reg} == cnt_reg - CW'(1)) begin
          state_next = S_RESP;
          go_resp    = 1'b1;
        end else begin
          idx_next = idx_reg + SW'(1);
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A duplicate or a full bucket suppresses the write; gating with rst_n lets
  // a reset abort a write that has not yet reached its edge.
  assign is_insert  = (res_op == OP_INSERT);
  assign do_write   = rst_n && go_resp && is_insert && !res_hit && (res_cnt < DEPTH_C);
  assign full_next  = is_insert && !res_hit && (res_cnt == DEPTH_C);
  assign slot_next  = res_hit ? res_slot : (do_write ? res_cnt[SW-1:0] : '0);
  assign count_next = do_write ? res_cnt + CW'(1) : res_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      hit_reg   <= 1'b0;
      full_reg  <= 1'b0;
      slot_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (go_resp) begin
        hit_reg   <= res_hit;
        full_reg  <= full_next;
        slot_reg  <= slot_next;
        count_reg <= count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    idx_reg <= idx_next;
    if (accept) begin
      op_reg  <= op_e'(bus.in_op);
      h1_reg  <= bus.in_h1;
      h2_reg  <= bus.in_h2;
      cnt_reg <= cnt_rd;
    end
  end

  bucket_mem #(
    .NUM_OF_BUCKETS (NUM_OF_BUCKETS),
    .BUCKET_DEPTH   (BUCKET_DEPTH),
    .SIG_WIDTH      (SIG_WIDTH)
  ) u_mem (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear && (state_reg == S_IDLE)),
    .cnt_rd_bucket (bus.in_h2),
    .cnt_rd        (cnt_rd),
    .cnt_wr_en     (do_write),
    .cnt_wr_bucket (res_h2),
    .cnt_wr_val    (count_next),
    .sig_rd_bucket (h2_reg),
    .sig_rd_slot   (idx_reg),
    .sig_rd        (sig_rd),
    .sig_wr_en     (do_write),
    .sig_wr_bucket (res_h2),
    .sig_wr_slot   (res_cnt[SW-1:0]),
    .sig_wr_data   (res_h1)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_reg == S_RESP);
  assign bus.out_hit   = hit_reg;
  assign bus.out_full  = full_reg;
  assign bus.out_slot  = slot_reg;
  assign bus.out_count = count_reg;

endmodule

// File: tb/tb_bucket_table.sv
// Directed bench for bucket_table: inserts, queries, full bucket, duplicates,
// clear and reset behaviour with hand-computed responses and latencies.
module tb_bucket_table;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  bucket_table_if bus ();

  bucket_table dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Response packing: {hit, full, slot[1:0], count[2:0]}
  function automatic logic [6:0] pk(input bit h, input bit f, input int s, input int c);
    return {h, f, 2'(s), 3'(c)};
  endfunction

  task automatic do_req(input logic op, input logic [31:0] h1, input logic [7:0] h2,
                        input bit ack, input bit clr_busy,
                        output logic [6:0] rsp, output int lat);
    int n;
    n = 0;
    rsp = 'x;
    lat = -1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_h1    = h1;
    bus.in_h2    = h2;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      vecs++; errs++;
      $display("FAIL accept_timeout in_ready=%0b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_h1    = 32'hDEAD_BEEF;
    bus.in_h2    = 8'hA5;
    if (clr_busy) clear = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    clear = 1'b0;
    if (!bus.out_valid) begin
      vecs++; errs++;
      $display("FAIL resp_timeout out_valid=%0b required 1", bus.out_valid);
      return;
    end
    rsp = {bus.out_hit, bus.out_full, bus.out_slot, bus.out_count};
    $display("txn op=%0d h1=%h h2=%0d hit=%0b full=%0b slot=%0d count=%0d lat=%0d",
             op, h1, h2, rsp[6], rsp[5], rsp[4:3], rsp[2:0], lat);
    if (ack) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    vecs++;
    if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    vecs++;
    if ({bus.out_hit, bus.out_full, bus.out_slot, bus.out_count} !== pk(0, 0, 0, 0)) begin
      errs++;
      $display("FAIL rst_outputs got %b want %b", {bus.out_hit, bus.out_full, bus.out_slot, bus.out_count}, pk(0, 0, 0, 0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_empty_query();
    logic [6:0] rsp; int lat;
    do_req(1'b1, 32'h1234_5678, 8'd5, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 0)) begin errs++; $display("FAIL empty_query rsp got %b want %b", rsp, pk(0, 0, 0, 0)); end
    vecs++;
    if (lat !== 1) begin errs++; $display("FAIL empty_query lat got %0d want 1", lat); end
  endtask

  task automatic test_fill();
    logic [6:0] rsp; int lat;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 32'hA + 32'(i), 8'd7, 1, 0, rsp, lat);
      vecs++;
      if (rsp !== pk(0, 0, i, i + 1)) begin errs++; $display("FAIL fill_%0d rsp got %b want %b", i, rsp, pk(0, 0, i, i + 1)); end
      vecs++;
      if (lat !== 1 + i) begin errs++; $display("FAIL fill_%0d lat got %0d want %0d", i, lat, 1 + i); end
    end
    do_req(1'b0, 32'hE, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 1, 0, 4)) begin errs++; $display("FAIL insert_full rsp got %b want %b", rsp, pk(0, 1, 0, 4)); end
    do_req(1'b1, 32'hD, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 3, 4)) begin errs++; $display("FAIL query_last rsp got %b want %b", rsp, pk(1, 0, 3, 4)); end
    vecs++;
    if (lat !== 5) begin errs++; $display("FAIL query_last lat got %0d want 5", lat); end
    do_req(1'b1, 32'hA, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 0, 4) || lat !== 2) begin errs++; $display("FAIL query_first rsp got %b lat %0d want %b lat 2", rsp, lat, pk(1, 0, 0, 4)); end
    do_req(1'b1, 32'hF, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 4) || lat !== 5) begin errs++; $display("FAIL query_miss_full rsp got %b lat %0d want %b lat 5", rsp, lat, pk(0, 0, 0, 4)); end
  endtask

  task automatic test_clear_idle();
    logic [6:0] rsp; int lat;
    @(negedge clk);
    clear = 1'b1;
    #1;
    vecs++;
    if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL clear_in_ready got %b want 0", bus.in_ready); end
    @(negedge clk);
    clear = 1'b0;
    do_req(1'b1, 32'hD, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 0) || lat !== 1) begin errs++; $display("FAIL after_clear rsp got %b lat %0d want %b lat 1", rsp, lat, pk(0, 0, 0, 0)); end
  endtask

  task automatic test_duplicate();
    logic [6:0] rsp; int lat;
    do_req(1'b0, 32'hA, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 1)) begin errs++; $display("FAIL dup_first rsp got %b want %b", rsp, pk(0, 0, 0, 1)); end
    do_req(1'b0, 32'hA, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 0, 1) || lat !== 2) begin errs++; $display("FAIL dup_second rsp got %b lat %0d want %b lat 2", rsp, lat, pk(1, 0, 0, 1)); end
    do_req(1'b0, 32'hB, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 1, 2) || lat !== 2) begin errs++; $display("FAIL dup_next rsp got %b lat %0d want %b lat 2", rsp, lat, pk(0, 0, 1, 2)); end
    do_req(1'b1, 32'hB, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 1, 2) || lat !== 3) begin errs++; $display("FAIL dup_query rsp got %b lat %0d want %b lat 3", rsp, lat, pk(1, 0, 1, 2)); end
  endtask

  task automatic test_bucket_edges();
    logic [6:0] rsp; int lat;
    do_req(1'b0, 32'hA, 8'd0, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 1)) begin errs++; $display("FAIL ins_b0 rsp got %b want %b", rsp, pk(0, 0, 0, 1)); end
    do_req(1'b0, 32'hA, 8'd255, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 1)) begin errs++; $display("FAIL ins_b255 rsp got %b want %b", rsp, pk(0, 0, 0, 1)); end
    do_req(1'b1, 32'hA, 8'd1, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 0)) begin errs++; $display("FAIL query_b1 rsp got %b want %b", rsp, pk(0, 0, 0, 0)); end
    do_req(1'b1, 32'hA, 8'd255, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 0, 1) || lat !== 2) begin errs++; $display("FAIL query_b255 rsp got %b lat %0d want %b lat 2", rsp, lat, pk(1, 0, 0, 1)); end
    do_req(1'b1, 32'hA, 8'd0, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 0, 1)) begin errs++; $display("FAIL query_b0 rsp got %b want %b", rsp, pk(1, 0, 0, 1)); end
  endtask

  task automatic test_stall();
    logic [6:0] rsp; int lat;
    logic [8:0] obs;
    do_req(1'b0, 32'h55, 8'd9, 0, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 1)) begin errs++; $display("FAIL stall_rsp got %b want %b", rsp, pk(0, 0, 0, 1)); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      obs = {bus.out_valid, bus.in_ready, bus.out_hit, bus.out_full, bus.out_slot, bus.out_count};
      vecs++;
      if (obs !== {2'b10, pk(0, 0, 0, 1)}) begin errs++; $display("FAIL stall_cycle_%0d got %b want %b", c, obs, {2'b10, pk(0, 0, 0, 1)}); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    vecs++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errs++; $display("FAIL stall_release valid,ready got %b want 01", {bus.out_valid, bus.in_ready}); end
  endtask

  task automatic test_clear_scan();
    logic [6:0] rsp; int lat;
    do_req(1'b0, 32'hC, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 2, 3)) begin errs++; $display("FAIL ins_third rsp got %b want %b", rsp, pk(0, 0, 2, 3)); end
    do_req(1'b1, 32'hC, 8'd7, 1, 1, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 2, 3) || lat !== 4) begin errs++; $display("FAIL clear_in_scan rsp got %b lat %0d want %b lat 4", rsp, lat, pk(1, 0, 2, 3)); end
    do_req(1'b1, 32'hA, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(1, 0, 0, 3)) begin errs++; $display("FAIL clear_ignored rsp got %b want %b", rsp, pk(1, 0, 0, 3)); end
  endtask

  task automatic test_reset_scan();
    logic [6:0] rsp; int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 1'b1;
    bus.in_h1    = 32'hC;
    bus.in_h2    = 8'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vecs++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin errs++; $display("FAIL rst_scan valid,ready got %b want 00", {bus.out_valid, bus.in_ready}); end
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errs++; $display("FAIL rst_scan_idle valid,ready got %b want 01", {bus.out_valid, bus.in_ready}); end
    do_req(1'b1, 32'hC, 8'd7, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 0) || lat !== 1) begin errs++; $display("FAIL rst_scan_b7 rsp got %b lat %0d want %b lat 1", rsp, lat, pk(0, 0, 0, 0)); end
    do_req(1'b1, 32'hA, 8'd255, 1, 0, rsp, lat);
    vecs++;
    if (rsp !== pk(0, 0, 0, 0)) begin errs++; $display("FAIL rst_scan_b255 rsp got %b want %b", rsp, pk(0, 0, 0, 0)); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_h1     = '0;
    bus.in_h2     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_empty_query();
    test_fill();
    test_clear_idle();
    test_duplicate();
    test_bucket_edges();
    test_stall();
    test_clear_scan();
    test_reset_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
